// File: rtl/regbus_reg_pkg.sv
// Shared offsets, handshake states and access types for the
// REGBUS event-counter register block.
package regbus_reg_pkg;

    localparam logic [11:0] OFF_STATUS = 12'h000;
    localparam logic [11:0] OFF_CTRL   = 12'h004;
    localparam logic [11:0] OFF_CFG    = 12'h008;
    localparam logic [11:0] OFF_SEC    = 12'h00C;
    localparam logic [11:0] OFF_ISTS   = 12'h010;
    localparam logic [11:0] OFF_IEN    = 12'h014;

    // 64-byte pages holding up to 16 per-channel words
    localparam logic [5:0] PG_COUNT  = 6'h04;
    localparam logic [5:0] PG_THRESH = 6'h08;

    localparam int CFG_W = 8;
    localparam int SEC_W = 8;

    localparam logic [CFG_W-1:0] CFG_RST = 8'h02;
    localparam logic [SEC_W-1:0] SEC_RST = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } bus_st_t;

    typedef enum logic [2:0] {
        ACC_RO,
        ACC_WO,
        ACC_RW,
        ACC_RW1,
        ACC_W1C,
        ACC_NONE
    } acc_t;

    typedef enum logic [3:0] {
        R_NONE,
        R_STATUS,
        R_CTRL,
        R_CFG,
        R_SEC,
        R_ISTS,
        R_IEN,
        R_CNT,
        R_THR
    } reg_sel_t;

endpackage

// File: rtl/regbus_evt_counter.sv
// One saturating event counter with its threshold register and a
// hit pulse when an increment lands exactly on the threshold.
module regbus_evt_counter #(
    parameter int CNT_W = 16
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             evt,
    input  logic             thr_we,
    input  logic [CNT_W-1:0] thr_wdata,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] thresh,
    output logic             hit
);

    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [CNT_W-1:0] inc;
    logic             bump;

    assign bump = evt && !clr && (count != CMAX);
    assign inc  = count + CNT_W'(1);
    // compare uses the threshold before any same-edge write
    assign hit  = bump && (inc == thresh);

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            count  <= '0;
            thresh <= CMAX;
        end else begin
            if (clr) begin
                count <= '0;
            end else if (bump) begin
                count <= inc;
            end
            if (thr_we) begin
                thresh <= thr_wdata;
            end
        end
    end

endmodule

// File: rtl/regbus_evt_reg_block.sv
// REGBUS slave: fixed control map plus NUM_CH event counters with
// threshold interrupts and programmable wait states.
module regbus_evt_reg_block
    import regbus_reg_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                NUM_CH      = 4,
    parameter int                CNT_W       = 16,
    parameter int                WAIT_STATES = 0
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [DATA_W-1:0] pwdata,
    output logic              pready,
    output logic [DATA_W-1:0] prdata,
    output logic              pslverr,
    input  logic [NUM_CH-1:0] event_i,
    output logic              irq_o
);

    localparam logic [2:0] WS  = 3'(WAIT_STATES);
    localparam logic [4:0] NCH = 5'(NUM_CH);

    bus_st_t  st, st_nx;
    acc_t     acc;
    reg_sel_t rsel;

    logic [2:0]        wcnt;
    logic              in_acc, rdy, err, wr;
    logic [ADDR_W:0]   diff;
    logic [ADDR_W-1:0] off;
    logic              in_blk, ch_ok;
    logic [3:0]        idx;
    logic [DATA_W-1:0] rdata;
    logic [CFG_W-1:0]  cfg;
    logic [SEC_W-1:0]  sec;
    logic              sec_lock, soft_clr, irq_q;
    logic [NUM_CH-1:0] ists, ien, hit, thr_we, w1c;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt, thr;
    logic              unused_bits;

    // borrow bit rejects addresses below the base
    assign diff   = {1'b0, paddr} - {1'b0, BASE_ADDR};
    assign off    = diff[ADDR_W-1:0];
    assign in_blk = !diff[ADDR_W] && (off[ADDR_W-1:12] == '0);
    assign idx    = off[5:2];
    assign ch_ok  = {1'b0, idx} < NCH;

    assign unused_bits = ^{pwdata, off[1:0]};

    always_comb begin
        acc  = ACC_NONE;
        rsel = R_NONE;
        if (in_blk && (paddr[1:0] == 2'b00)) begin
            unique case (1'b1)
                off[11:0] == OFF_STATUS: begin acc = ACC_RO;  rsel = R_STATUS; end
                off[11:0] == OFF_CTRL:   begin acc = ACC_WO;  rsel = R_CTRL;   end
                off[11:0] == OFF_CFG:    begin acc = ACC_RW;  rsel = R_CFG;    end
                off[11:0] == OFF_SEC:    begin acc = ACC_RW1; rsel = R_SEC;    end
                off[11:0] == OFF_ISTS:   begin acc = ACC_W1C; rsel = R_ISTS;   end
                off[11:0] == OFF_IEN:    begin acc = ACC_RW;  rsel = R_IEN;    end
                (off[11:6] == PG_COUNT) && ch_ok:  begin acc = ACC_RO; rsel = R_CNT; end
                (off[11:6] == PG_THRESH) && ch_ok: begin acc = ACC_RW; rsel = R_THR; end
                default: ;
            endcase
        end
    end

    assign err = (acc == ACC_NONE)
              || (pwrite && (acc == ACC_RO))
              || (!pwrite && (acc == ACC_WO));
    assign wr  = rdy && pwrite && !err;

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            st <= ST_IDLE;
        end else begin
            st <= st_nx;
        end
    end

    always_comb begin
        st_nx = st;
        unique case (st)
            ST_IDLE: begin
                if (psel && !penable) st_nx = ST_SETUP;
            end
            ST_SETUP, ST_ACCESS: begin
                if (!psel)         st_nx = ST_IDLE;
                else if (!penable) st_nx = ST_SETUP;
                else if (rdy)      st_nx = ST_IDLE;
                else               st_nx = ST_ACCESS;
            end
            default: st_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        in_acc = (st != ST_IDLE) && psel && penable;
        rdy    = in_acc && (wcnt == WS);
    end

    always_ff @(posedge pclk) begin
        if (!rst_n || !in_acc || rdy) begin
            wcnt <= '0;
        end else begin
            wcnt <= wcnt + 3'd1;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (rsel)
            R_STATUS: rdata[NUM_CH-1:0] = ists & ien;
            R_CFG:    rdata[CFG_W-1:0]  = cfg;
            R_SEC:    rdata[SEC_W-1:0]  = sec;
            R_ISTS:   rdata[NUM_CH-1:0] = ists;
            R_IEN:    rdata[NUM_CH-1:0] = ien;
            R_CNT, R_THR: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (idx == 4'(i)) begin
                        rdata[CNT_W-1:0] = (rsel == R_CNT) ? cnt[i] : thr[i];
                    end
                end
            end
            default: ;
        endcase
    end

    // outputs forced quiet while reset is held, even mid-transfer
    assign pready  = rst_n && rdy;
    assign pslverr = rst_n && rdy && err;
    assign prdata  = (rst_n && rdy && !pwrite && !err) ? rdata : '0;
    assign irq_o   = rst_n && irq_q;

    assign soft_clr = wr && (rsel == R_CTRL) && pwdata[0];
    assign w1c      = (wr && (rsel == R_ISTS)) ? pwdata[NUM_CH-1:0] : '0;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign thr_we[g] = wr && (rsel == R_THR) && (idx == 4'(g));
        regbus_evt_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .pclk     (pclk),
            .rst_n    (rst_n),
            .clr      (soft_clr),
            .evt      (event_i[g]),
            .thr_we   (thr_we[g]),
            .thr_wdata(pwdata[CNT_W-1:0]),
            .count    (cnt[g]),
            .thresh   (thr[g]),
            .hit      (hit[g])
        );
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            cfg      <= CFG_RST;
            sec      <= SEC_RST;
            sec_lock <= 1'b0;
            ists     <= '0;
            ien      <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (wr && (rsel == R_CFG)) begin
                cfg <= pwdata[CFG_W-1:0];
            end
            if (wr && (rsel == R_SEC) && !sec_lock) begin
                sec      <= pwdata[SEC_W-1:0];
                sec_lock <= 1'b1;
            end
            if (wr && (rsel == R_IEN)) begin
                ien <= pwdata[NUM_CH-1:0];
            end
            // a new hit wins over a same-edge clear
            ists  <= (ists & ~w1c) | hit;
            irq_q <= |(ists & ien);
        end
    end

endmodule

// File: tb/tb_regbus_evt_reg_block.sv
// Bench for regbus_evt_reg_block: register-map model compared every
// cycle, plus directed transfers with literal expectations.
module tb_regbus_evt_reg_block;

    localparam int NCH  = 4;
    localparam int WS   = 2;
    localparam int CMAX = 65535;

    logic            pclk    = 1'b0;
    logic            rst_n   = 1'b0;
    logic            psel    = 1'b0;
    logic            penable = 1'b0;
    logic            pwrite  = 1'b0;
    logic [31:0]     paddr   = '0;
    logic [31:0]     pwdata  = '0;
    logic [NCH-1:0]  ev      = '0;
    logic            pready, pslverr, irq;
    logic [31:0]     prdata;

    int checks = 0;
    int errors = 0;

    int             m_cnt [NCH] = '{default: 0};
    int             m_thr [NCH] = '{default: CMAX};
    logic [7:0]     m_cfg  = 8'h02;
    logic [7:0]     m_sec  = 8'h03;
    logic           m_lock = 1'b0;
    logic [NCH-1:0] m_ists = '0;
    logic [NCH-1:0] m_ien  = '0;
    logic           m_irq  = 1'b0;
    bit             armed  = 1'b0;
    int             acc    = 0;

    always #5 pclk = ~pclk;

    regbus_evt_reg_block #(
        .NUM_CH     (NCH),
        .WAIT_STATES(WS)
    ) dut (
        .pclk   (pclk),
        .rst_n  (rst_n),
        .paddr  (paddr),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .pwdata (pwdata),
        .pready (pready),
        .prdata (prdata),
        .pslverr(pslverr),
        .event_i(ev),
        .irq_o  (irq)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h at %0t", nm, got, want, $time);
        end
    endtask

    // expected error and read data of an access, from the map rules
    function automatic void mexp(input logic [31:0] a, input logic w,
                                 output logic e, output logic [31:0] r);
        int o;
        e = 1'b1;
        r = '0;
        if (a < 32'h1000 && a[1:0] == 2'b00) begin
            o = int'(a);
            if (o == 'h00) begin e = w; r = 32'(m_ists & m_ien); end
            else if (o == 'h04) e = !w;
            else if (o == 'h08) begin e = 1'b0; r = 32'(m_cfg); end
            else if (o == 'h0C) begin e = 1'b0; r = 32'(m_sec); end
            else if (o == 'h10) begin e = 1'b0; r = 32'(m_ists); end
            else if (o == 'h14) begin e = 1'b0; r = 32'(m_ien); end
            else if (o >= 'h100 && o < 'h100 + 4 * NCH) begin
                e = w; r = 32'(m_cnt[(o - 'h100) / 4]);
            end else if (o >= 'h200 && o < 'h200 + 4 * NCH) begin
                e = 1'b0; r = 32'(m_thr[(o - 'h200) / 4]);
            end
        end
        if (e || w) r = '0;
    endfunction

    always @(posedge pclk) begin
        logic           e, commit, clr;
        logic [31:0]    r;
        logic [NCH-1:0] hits;
        int             o;
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                m_cnt[i] = 0;
                m_thr[i] = CMAX;
            end
            m_cfg = 8'h02; m_sec = 8'h03; m_lock = 1'b0;
            m_ists = '0; m_ien = '0; m_irq = 1'b0;
            armed = 1'b0; acc = 0;
        end else begin
            commit = 1'b0;
            if (psel && !penable) begin
                armed = 1'b1; acc = 0;
            end else if (psel && penable && armed) begin
                if (acc == WS) begin
                    commit = 1'b1; armed = 1'b0; acc = 0;
                end else begin
                    acc++;
                end
            end else begin
                armed = 1'b0; acc = 0;
            end
            mexp(paddr, pwrite, e, r);
            commit = commit && pwrite && !e;
            o = int'(paddr);
            clr = commit && o == 'h04 && pwdata[0];
            hits = '0;
            for (int i = 0; i < NCH; i++) begin
                if (ev[i] && !clr && m_cnt[i] < CMAX) begin
                    m_cnt[i]++;
                    if (m_cnt[i] == m_thr[i]) hits[i] = 1'b1;
                end
                if (clr) m_cnt[i] = 0;
            end
            m_irq = |(m_ists & m_ien);
            if (commit) begin
                if (o == 'h08) m_cfg = pwdata[7:0];
                if (o == 'h0C && !m_lock) begin m_sec = pwdata[7:0]; m_lock = 1'b1; end
                if (o == 'h10) m_ists = m_ists & ~pwdata[NCH-1:0];
                if (o == 'h14) m_ien = pwdata[NCH-1:0];
                if (o >= 'h200 && o < 'h200 + 4 * NCH) m_thr[(o - 'h200) / 4] = int'(pwdata[15:0]);
            end
            m_ists = m_ists | hits;
        end
    end

    always @(negedge pclk) begin
        logic        e, er;
        logic [31:0] r;
        er = rst_n && psel && penable && armed && (acc == WS);
        chk("pready", 32'(pready), 32'(er));
        if (er) begin
            mexp(paddr, pwrite, e, r);
            chk("pslverr", 32'(pslverr), 32'(e));
            chk("prdata", prdata, r);
        end else begin
            chk("pslverr_idle", 32'(pslverr), 32'd0);
            chk("prdata_idle", prdata, 32'd0);
        end
        chk("irq_o", 32'(irq), 32'(rst_n && m_irq));
    end

    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int waits);
        bit got = 1'b0;
        rd = '0; er = 1'b0; waits = 0;
        @(posedge pclk); #1;
        paddr = a; pwrite = w; pwdata = d; psel = 1'b1; penable = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        for (int k = 0; k < 16 && !got; k++) begin
            @(negedge pclk);
            if (pready) begin
                got = 1'b1; rd = prdata; er = pslverr;
            end else begin
                waits++;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL timeout addr 0x%0h got no pready want pready", a);
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic we, input string nm);
        logic [31:0] r; logic e; int w;
        xfer(a, 1'b1, d, r, e, w);
        chk(nm, 32'(e), 32'(we));
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] want, input logic we, input string nm);
        logic [31:0] r; logic e; int w;
        xfer(a, 1'b0, '0, r, e, w);
        chk(nm, r, want);
        chk("rd_err", 32'(e), 32'(we));
    endtask

    initial begin
        logic [31:0] r; logic e; int w;
        repeat (3) @(posedge pclk);
        #1 rst_n = 1'b1;

        xfer(32'h08, 1'b0, '0, r, e, w);
        chk("cfg_rst", r, 32'h2);
        chk("ws_low_cycles", 32'(w), 32'd2);
        rd(32'h0C,  32'h3,    1'b0, "sec_rst");
        rd(32'h204, 32'hFFFF, 1'b0, "thr1_rst");
        rd(32'h20C, 32'hFFFF, 1'b0, "thr3_rst");
        rd(32'h100, 32'h0,    1'b0, "cnt0_rst");
        rd(32'h00,  32'h0,    1'b0, "status_rst");
        rd(32'h10,  32'h0,    1'b0, "ists_rst");
        rd(32'h14,  32'h0,    1'b0, "ien_rst");

        wr(32'h0C, 32'hAA, 1'b0, "sec_wr1");
        wr(32'h0C, 32'h55, 1'b0, "sec_wr2");
        rd(32'h0C, 32'hAA, 1'b0, "sec_locked");

        wr(32'h204, 32'h3, 1'b0, "thr1_wr");
        wr(32'h14,  32'h2, 1'b0, "ien_wr");
        @(posedge pclk); #1 ev = 4'b0010;
        repeat (3) @(posedge pclk);
        #1 ev = '0;
        chk("irq_pre", 32'(irq), 32'd0);
        @(posedge pclk); #1;
        chk("irq_rise", 32'(irq), 32'd1);
        rd(32'h104, 32'h3, 1'b0, "cnt1_three");
        rd(32'h00,  32'h2, 1'b0, "status_irq");
        wr(32'h10,  32'h2, 1'b0, "w1c_wr");
        chk("irq_hold", 32'(irq), 32'd1);
        @(posedge pclk); #1;
        chk("irq_fall", 32'(irq), 32'd0);

        wr(32'h08,   32'h5, 1'b0, "cfg_wr");
        wr(32'h00,   32'hF, 1'b1, "wr_status");
        rd(32'h04,   32'h0, 1'b1, "rd_ctrl");
        rd(32'h300,  32'h0, 1'b1, "rd_300");
        rd(32'h110,  32'h0, 1'b1, "rd_cnt_oob");
        wr(32'h210,  32'h1, 1'b1, "wr_thr_oob");
        wr(32'h1001, 32'h7, 1'b1, "wr_1001");
        wr(32'h09,   32'h7, 1'b1, "wr_misalign");
        wr(32'h2008, 32'h7, 1'b1, "wr_outside");
        rd(32'h08,   32'h5, 1'b0, "cfg_kept");
        rd(32'h10,   32'h0, 1'b0, "ists_kept");

        ev = 4'b0011;
        wr(32'h04, 32'h1, 1'b0, "soft_clr");
        ev = '0;
        rd(32'h100, 32'h0, 1'b0, "cnt0_clr");
        rd(32'h104, 32'h0, 1'b0, "cnt1_clr");

        ev = 4'b0001;
        repeat (70000) @(posedge pclk);
        #1 ev = '0;
        rd(32'h100, 32'hFFFF, 1'b0, "cnt0_sat");
        rd(32'h10,  32'h1,    1'b0, "ists_sat");
        rd(32'h00,  32'h0,    1'b0, "status_masked");

        @(posedge pclk); #1;
        paddr = 32'h08; pwrite = 1'b1; pwdata = 32'h9; psel = 1'b1; penable = 1'b0;
        @(posedge pclk); #1 penable = 1'b1;
        repeat (2) @(posedge pclk);
        #1 rst_n = 1'b0;
        @(negedge pclk);
        chk("rst_pready", 32'(pready), 32'd0);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge pclk); #1 rst_n = 1'b1;
        rd(32'h08,  32'h2, 1'b0, "cfg_after_rst");
        rd(32'h0C,  32'h3, 1'b0, "sec_after_rst");
        rd(32'h100, 32'h0, 1'b0, "cnt0_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
